// File: rtl/traffic_pkg.sv
// traffic_pkg: shared state codes, light encodings and timer width for traffic_light_ctrl.
package traffic_pkg;
  localparam int TMR_W = 6;
  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;
  typedef logic [2:0] state_t;
  localparam state_t ST_NS_G = 3'd0;
  localparam state_t ST_NS_Y = 3'd1;
  localparam state_t ST_RED1 = 3'd2;
  localparam state_t ST_EW_G = 3'd3;
  localparam state_t ST_EW_Y = 3'd4;
  localparam state_t ST_RED2 = 3'd5;
  localparam state_t ST_WALK = 3'd6;
endpackage

// File: rtl/traffic_light_ctrl_rise_detect.sv
// rise_detect: one-cycle pulse per 0->1 transition of level; a level already high at reset release is not an edge.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic pulse
);
  logic level_d, armed;
  always_ff @(posedge clk) begin
    if (reset) begin
      level_d <= 1'b0;
      armed   <= ~level;
    end else begin
      level_d <= level;
      armed   <= armed | ~level;
    end
  end
  assign pulse = level & ~level_d & armed;
endmodule

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: NS/EW light sequencer stepped by 1 Hz ticks; define PED_XING_EN to add the pedestrian WALK phase.
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int GREEN_S  = 10,
  parameter int YELLOW_S = 3,
  parameter int ALLRED_S = 1,
  parameter int WALK_S   = 8
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             clk_1Hz,
  input  logic             ped_req,
  output logic [2:0]       ns_light,
  output logic [2:0]       ew_light,
  output logic             walk,
  output logic [TMR_W-1:0] sec_left
);
  logic tick, expire;
  state_t state, nxt;
  logic [TMR_W-1:0] tmr, nxt_dur;
  rise_detect u_rise (.clk(clk_100MHz), .reset(reset), .level(clk_1Hz), .pulse(tick));
  assign expire = tick && tmr == '0;
`ifdef PED_XING_EN
  logic ped_pending, next_ew, to_walk;
  assign to_walk = expire && ped_pending && (state == ST_NS_Y || state == ST_EW_Y);
  // a request in the clearing cycle keeps the pending flag set
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      ped_pending <= 1'b0;
      next_ew     <= 1'b0;
    end else begin
      ped_pending <= ped_req || (ped_pending && !to_walk);
      if (to_walk) next_ew <= state == ST_NS_Y;
    end
  end
  always_comb begin
    nxt = ST_NS_G;
    case (state)
      ST_NS_G: nxt = ST_NS_Y;
      ST_NS_Y: nxt = ped_pending ? ST_WALK : ST_RED1;
      ST_RED1: nxt = ST_EW_G;
      ST_EW_G: nxt = ST_EW_Y;
      ST_EW_Y: nxt = ped_pending ? ST_WALK : ST_RED2;
      ST_WALK: nxt = next_ew ? ST_EW_G : ST_NS_G;
      default: nxt = ST_NS_G;
    endcase
  end
  assign walk = state == ST_WALK;
`else
  logic unused_ped;
  assign unused_ped = ped_req;
  always_comb begin
    nxt = ST_NS_G;
    case (state)
      ST_NS_G: nxt = ST_NS_Y;
      ST_NS_Y: nxt = ST_RED1;
      ST_RED1: nxt = ST_EW_G;
      ST_EW_G: nxt = ST_EW_Y;
      ST_EW_Y: nxt = ST_RED2;
      default: nxt = ST_NS_G;
    endcase
  end
  assign walk = 1'b0;
`endif
  assign nxt_dur = (nxt == ST_NS_G || nxt == ST_EW_G) ? TMR_W'(GREEN_S - 1) :
                   (nxt == ST_NS_Y || nxt == ST_EW_Y) ? TMR_W'(YELLOW_S - 1) :
                   (nxt == ST_WALK) ? TMR_W'(WALK_S - 1) : TMR_W'(ALLRED_S - 1);
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state <= ST_RED2;
      tmr   <= TMR_W'(ALLRED_S - 1);
    end else if (expire) begin
      state <= nxt;
      tmr   <= nxt_dur;
    end else if (tick) begin
      tmr <= tmr - 1'b1;
    end
  end
  assign ns_light = state == ST_NS_G ? LT_GRN : state == ST_NS_Y ? LT_YEL : LT_RED;
  assign ew_light = state == ST_EW_G ? LT_GRN : state == ST_EW_Y ? LT_YEL : LT_RED;
  assign sec_left = tmr;
endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb_traffic_light_ctrl: randomized self-checking bench against a phase/elapsed-seconds model of the light sequence.
module tb_traffic_light_ctrl;
`ifdef PED_XING_EN
  localparam bit PED = 1'b1;
`else
  localparam bit PED = 1'b0;
`endif
  localparam int P_NSG = 0, P_NSY = 1, P_R1 = 2, P_EWG = 3, P_EWY = 4, P_R2 = 5, P_WALK = 6;
  logic clk = 1'b0, reset = 1'b0, clk_1Hz = 1'b0, ped_req = 1'b0;
  logic [2:0] ns_light, ew_light;
  logic walk;
  logic [5:0] sec_left;
  int checks = 0, failures = 0;
  int m_ph, m_el;
  bit m_pend, m_nxt_ew, ped_hold;

  traffic_light_ctrl #(.GREEN_S(4), .YELLOW_S(2), .ALLRED_S(1), .WALK_S(3)) dut (
    .clk_100MHz(clk), .reset(reset), .clk_1Hz(clk_1Hz), .ped_req(ped_req),
    .ns_light(ns_light), .ew_light(ew_light), .walk(walk), .sec_left(sec_left)
  );

  always #5 clk = ~clk;

  function automatic int dur(int ph);
    if (ph == P_NSG || ph == P_EWG) return 4;
    if (ph == P_NSY || ph == P_EWY) return 2;
    if (ph == P_WALK) return 3;
    return 1;
  endfunction

  function automatic void m_reset();
    m_ph = P_R2; m_el = 0; m_pend = 0; m_nxt_ew = 0;
  endfunction

  // one second elapses; the phase ends once it has lasted its full duration
  function automatic void m_tick();
    m_el++;
    if (m_el < dur(m_ph)) return;
    m_el = 0;
    if (PED && m_pend && (m_ph == P_NSY || m_ph == P_EWY)) begin
      m_nxt_ew = m_ph == P_NSY;
      m_pend = 0;
      m_ph = P_WALK;
    end else if (m_ph == P_WALK) m_ph = m_nxt_ew ? P_EWG : P_NSG;
    else m_ph = (m_ph + 1) % 6;
  endfunction

  function automatic logic [12:0] m_out();
    logic [2:0] n, e;
    n = m_ph == P_NSG ? 3'b001 : m_ph == P_NSY ? 3'b010 : 3'b100;
    e = m_ph == P_EWG ? 3'b001 : m_ph == P_EWY ? 3'b010 : 3'b100;
    return {n, e, m_ph == P_WALK, 6'(dur(m_ph) - 1 - m_el)};
  endfunction

  task automatic do_reset();
    @(negedge clk); reset = 1'b1; ped_req = 1'b0; ped_hold = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_reset();
  endtask

  task automatic sec(input bit ped);
    @(negedge clk); clk_1Hz = 1'b1; ped_req = ped | ped_hold;
    @(negedge clk); ped_req = ped_hold;
    m_tick();
    if (PED && (ped || ped_hold)) m_pend = 1;
    repeat ($urandom_range(2, 0)) @(negedge clk);
    clk_1Hz = 1'b0;
    repeat ($urandom_range(3, 1)) @(negedge clk);
  endtask

  task automatic ped_pulse();
    @(negedge clk); ped_req = 1'b1;
    @(negedge clk); ped_req = ped_hold;
    if (PED) m_pend = 1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({ns_light, ew_light, walk, sec_left} !== 13'b100_100_0_000000) begin
      failures++; $display("FAIL reset_out: got %b expected %b", {ns_light, ew_light, walk, sec_left}, 13'b100_100_0_000000);
    end
    sec(0);
    checks++;
    if ({ns_light, ew_light, walk, sec_left} !== {3'b001, 3'b100, 1'b0, 6'd3}) begin
      failures++; $display("FAIL first_tick: got %b expected %b", {ns_light, ew_light, walk, sec_left}, {3'b001, 3'b100, 1'b0, 6'd3});
    end
  endtask

  task automatic test_full_cycle();
    for (int i = 0; i < 14; i++) begin
      sec(0);
      checks++;
      if ({ns_light, ew_light, walk, sec_left} !== m_out()) begin
        failures++; $display("FAIL full_cycle[%0d]: got %b expected %b", i, {ns_light, ew_light, walk, sec_left}, m_out());
      end
      checks++;
      if (!$onehot(ns_light) || !$onehot(ew_light)) begin
        failures++; $display("FAIL onehot[%0d]: got ns=%b ew=%b expected one-hot", i, ns_light, ew_light);
      end
    end
    checks++;
    if ({ns_light, ew_light, walk, sec_left} !== {3'b001, 3'b100, 1'b0, 6'd3}) begin
      failures++; $display("FAIL cycle_return: got %b expected %b", {ns_light, ew_light, walk, sec_left}, {3'b001, 3'b100, 1'b0, 6'd3});
    end
  endtask

  task automatic test_ped_walk();
    do_reset();
    sec(0);
    ped_pulse();
    for (int i = 0; i < 12; i++) begin
      sec(0);
      checks++;
      if ({ns_light, ew_light, walk, sec_left} !== m_out()) begin
        failures++; $display("FAIL ped_walk[%0d]: got %b expected %b", i, {ns_light, ew_light, walk, sec_left}, m_out());
      end
    end
  endtask

  task automatic test_ped_held();
    do_reset();
    repeat (5) sec(0);
    @(negedge clk); ped_hold = 1; ped_req = 1'b1;
    if (PED) m_pend = 1;
    repeat (3) sec(0);
    checks++;
    if (walk !== PED) begin
      failures++; $display("FAIL ped_held_walk: got %b expected %b", walk, PED);
    end
    @(negedge clk); ped_hold = 0; ped_req = 1'b0;
    for (int i = 0; i < 11; i++) begin
      sec(0);
      checks++;
      if ({ns_light, ew_light, walk, sec_left} !== m_out()) begin
        failures++; $display("FAIL ped_held[%0d]: got %b expected %b", i, {ns_light, ew_light, walk, sec_left}, m_out());
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (9) sec(0);
    checks++;
    if ({ns_light, ew_light, walk, sec_left} !== {3'b100, 3'b001, 1'b0, 6'd2}) begin
      failures++; $display("FAIL mid_ewg: got %b expected %b", {ns_light, ew_light, walk, sec_left}, {3'b100, 3'b001, 1'b0, 6'd2});
    end
    ped_pulse();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    m_reset();
    checks++;
    if ({ns_light, ew_light, walk, sec_left} !== 13'b100_100_0_000000) begin
      failures++; $display("FAIL mid_reset: got %b expected %b", {ns_light, ew_light, walk, sec_left}, 13'b100_100_0_000000);
    end
    for (int i = 0; i < 7; i++) begin
      sec(0);
      checks++;
      if ({ns_light, ew_light, walk, sec_left} !== m_out()) begin
        failures++; $display("FAIL after_mid_reset[%0d]: got %b expected %b", i, {ns_light, ew_light, walk, sec_left}, m_out());
      end
    end
  endtask

  task automatic test_1hz_high_release();
    @(negedge clk); clk_1Hz = 1'b1;
    do_reset();
    repeat (5) @(negedge clk);
    checks++;
    if ({ns_light, ew_light, walk, sec_left} !== 13'b100_100_0_000000) begin
      failures++; $display("FAIL high_release: got %b expected %b", {ns_light, ew_light, walk, sec_left}, 13'b100_100_0_000000);
    end
    clk_1Hz = 1'b0;
    repeat (2) @(negedge clk);
    sec(0);
    checks++;
    if ({ns_light, ew_light, walk, sec_left} !== {3'b001, 3'b100, 1'b0, 6'd3}) begin
      failures++; $display("FAIL high_release_tick: got %b expected %b", {ns_light, ew_light, walk, sec_left}, {3'b001, 3'b100, 1'b0, 6'd3});
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(3, 0) == 0) ped_pulse();
      sec($urandom_range(7, 0) == 0);
      checks++;
      if ({ns_light, ew_light, walk, sec_left} !== m_out()) begin
        failures++; $display("FAIL random[%0d]: got %b expected %b", i, {ns_light, ew_light, walk, sec_left}, m_out());
      end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_full_cycle();
    test_ped_walk();
    test_ped_held();
    test_reset_mid();
    test_1hz_high_release();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/traffic_light_ctrl.md
# traffic_light_ctrl

Downstream consumer of the 1 Hz generator: a two-road (NS/EW) traffic-light sequencer clocked by the 100 MHz board clock. It edge-detects the 1 Hz square wave into a one-cycle second tick and steps a Moore state machine through green/yellow/all-red phases with per-phase second counters. An optional pedestrian phase inserts an all-red WALK interval on request. Light outputs drive the BASYS 3 LEDs/PMOD directly.

## Interface
Parameters:
- GREEN_S, 10, green duration in seconds (1..63)
- YELLOW_S, 3, yellow duration in seconds (1..63)
- ALLRED_S, 1, all-red clearance in seconds (1..63)
- WALK_S, 8, pedestrian walk duration in seconds (1..63)

Ports:
- clk_100MHz  in  1  system clock; sole clock of the block
- reset  in  1  synchronous, active-high (btnC)
- clk_1Hz  in  1  1 Hz square wave, generated from the same clock domain
- ped_req  in  1  pedestrian button level, active-high
- ns_light  out  3  {red, yellow, green}, one-hot
- ew_light  out  3  {red, yellow, green}, one-hot
- walk  out  1  pedestrian walk lamp
- sec_left  out  6  seconds remaining in current phase minus 1 (timer value)

## Operation
- tick = clk_1Hz & ~clk_1Hz_d (clk_1Hz_d: one flop); exactly one-cycle pulse per rising edge.
- States: NS_G, NS_Y, RED1, EW_G, EW_Y, RED2, WALK.
- Sequence: NS_G -> NS_Y -> RED1 -> EW_G -> EW_Y -> RED2 -> NS_G.
- Phase timer loaded with duration-1 on state entry; on tick: if timer==0 transition, else decrement. Each phase lasts exactly its duration in ticks.
- Outputs are Moore decode of state: NS_G ns=G ew=R; NS_Y ns=Y ew=R; RED1/RED2/WALK both R; EW_G ew=G ns=R; EW_Y ew=Y ns=R. walk=1 only in WALK.
- Pedestrian: ped_pending set by any cycle with ped_req=1. On NS_Y or EW_Y expiry with ped_pending=1: go to WALK (instead of RED1/RED2), clear ped_pending, record next_ew (1 after NS_Y, 0 after EW_Y). WALK expiry -> EW_G if next_ew else NS_G.
- ped_req high in the same cycle as the clear: set wins, pending stays 1. Requests during WALK are serviced on the next yellow expiry.
- Reset (any cycle, including mid-phase): state RED2, timer ALLRED_S-1, ped_pending=0, next_ew=0, clk_1Hz_d=0. Output reset values: ns_light=3'b100, ew_light=3'b100, walk=0, sec_left=ALLRED_S-1.
- Ticks during reset are ignored; first tick after reset release counts.

## Timing
- tick asserted in cycle N (clk_1Hz sampled 1, clk_1Hz_d 0); state/timer update at the end of cycle N; outputs reflect the new state in cycle N+1 (one-clock latency from detected edge).
- sec_left is the timer register; updates on the same edge as state.
- clk_1Hz high at reset release: no tick generated until a subsequent 0->1 transition.
- No multi-cycle paths; all logic single-cycle at 100 MHz.

## Configuration
- PED_XING_EN defined: pedestrian logic compiled in as above.
- PED_XING_EN undefined: ped_req ignored (port kept), ped_pending/next_ew/WALK state removed, walk tied 0; yellow expiry always goes to RED1/RED2.

## Structure
- Shared package traffic_pkg: state enum, light constants LT_RED=3'b100, LT_YEL=3'b010, LT_GRN=3'b001, timer width constant TMR_W=6.
- One sub-module: rise_detect (clk, reset, level in, pulse out) producing tick.

## Test plan
- Reset with GREEN_S=4, YELLOW_S=2, ALLRED_S=1: outputs 100/100, walk=0, sec_left=0; after 1 tick ns=001, sec_left=3.
- Full cycle, no ped_req: 14 ticks return to NS_G; each phase lasts 4/2/1/4/2/1 ticks; one-hot lights throughout.
- ped_req pulsed 1 cycle during NS_G, WALK_S=3: after NS_Y, walk=1 both red for 3 ticks, then EW_G; RED1 skipped.
- ped_req held high across WALK entry: pending stays set; WALK occurs again after EW_Y, then NS_G.
- reset asserted mid-EW_G with sec_left=2: next cycle state RED2, outputs 100/100, sec_left=0, pending cleared.
- clk_1Hz held high through reset release: no transition until next rising edge; with PED_XING_EN undefined, ped_req=1 never asserts walk.
